// File: rtl/dma_stream_mc.sv
// ---------------------------------------------------------------------------
// dma_stream_mc
//   Multi-channel descriptor DMA. The CPU posts descriptors over a Wishbone
//   slave port. Each descriptor is fetched from DRAM in fixed-length bursts.
//   The returned words land in a channel-tagged output buffer, and each word
//   is delivered to its descriptor's accelerator channel with valid/ready
//   handshaking.
//
// Ports
//   wb_clk_i / wb_rst_n_i      clock, asynchronous active-low reset
//   cpu_wbs_*                  CPU slave: descriptor write, status read
//   dram_wbs_ack_o             DRAM accepted the burst request
//   dram_burst_en_o            DRAM beat valid, data on dram_wbs_dat_o
//   dram_wbs_cyc/stb/we/adr_i  DRAM burst request (read only)
//   dram_fun_sel               fun_sel bit of the active descriptor
//   acc_data_valid_i[NUM_CH]   per-channel valid (only head channel active)
//   acc_data_ready_o[NUM_CH]   per-channel ready
//   acc_data_i                 shared data bus (output buffer head)
//   dma_done_o                 one-cycle pulse per completed descriptor
//   dma_err_o                  sticky error (bad channel / misaligned)
// ---------------------------------------------------------------------------
module dma_stream_mc #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int          NUM_CH     = 2,
    parameter int          DESC_DEPTH = 4,
    parameter int          BURST_LEN  = 4,
    parameter int          OBUF_DEPTH = 8,
    parameter logic [7:0]  CMD_TAG    = 8'h30,
    parameter logic [31:0] DRAM_BASE  = 32'h3800_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  cpu_wbs_stb_i,
    input  logic                  cpu_wbs_cyc_i,
    input  logic                  cpu_wbs_we_i,
    input  logic [3:0]            cpu_wbs_sel_i,
    input  logic [31:0]           cpu_wbs_adr_i,
    input  logic [31:0]           cpu_wbs_dat_i,
    output logic                  cpu_wbs_ack_o,
    output logic [31:0]           cpu_wbs_dat_o,
    input  logic                  dram_wbs_ack_o,
    input  logic                  dram_burst_en_o,
    input  logic [DATA_WIDTH-1:0] dram_wbs_dat_o,
    output logic                  dram_fun_sel,
    output logic                  dram_wbs_stb_i,
    output logic                  dram_wbs_cyc_i,
    output logic                  dram_wbs_we_i,
    output logic [31:0]           dram_wbs_adr_i,
    output logic [NUM_CH-1:0]     acc_data_valid_i,
    input  logic [NUM_CH-1:0]     acc_data_ready_o,
    output logic [DATA_WIDTH-1:0] acc_data_i,
    output logic                  dma_done_o,
    output logic                  dma_err_o
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DP_W   = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int DC_W   = $clog2(DESC_DEPTH + 1);
    localparam int OP_W   = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int OC_W   = $clog2(OBUF_DEPTH + 1);
    localparam int BC_W   = $clog2(BURST_LEN + 1);
    localparam int DESC_W = 1 + CH_W + 2 * ADDR_WIDTH;
    localparam int OBUF_W = CH_W + DATA_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // ---------------- CPU slave decode ----------------
    logic            cpu_hit;
    logic [CH_W-1:0] cpu_ch;
    logic            ch_bad;
    logic            desc_full;
    logic            desc_push;
    logic            desc_pop;
    logic            cpu_ack_reg, cpu_ack_next;
    logic [31:0]     cpu_dat_reg, cpu_dat_next;

    // The ~ack term makes a held strobe produce exactly one ack per access.
    assign cpu_hit = cpu_wbs_cyc_i & cpu_wbs_stb_i &
                     (cpu_wbs_adr_i[31:24] == CMD_TAG) & ~cpu_wbs_ack_o;
    assign cpu_ch  = cpu_wbs_adr_i[4 +: CH_W];
    assign ch_bad  = int'(cpu_ch) >= NUM_CH;

    // Fullness comes from the registered count, so a pop in the same cycle
    // cannot admit a new write until the next cycle.
    assign desc_push    = cpu_hit & cpu_wbs_we_i & ~ch_bad & ~desc_full;
    assign cpu_ack_next = cpu_hit & (~cpu_wbs_we_i | ch_bad | ~desc_full);

    // ---------------- descriptor FIFO ----------------
    logic [DESC_W-1:0] desc_mem [DESC_DEPTH];
    logic [DP_W-1:0]   desc_wr_ptr_reg, desc_rd_ptr_reg;
    logic [DC_W-1:0]   desc_cnt_reg;
    logic [DESC_W-1:0] desc_head;

    assign desc_full = (desc_cnt_reg == DC_W'(DESC_DEPTH));
    assign desc_head = desc_mem[desc_rd_ptr_reg];

    always_ff @(posedge wb_clk_i) begin
        if (desc_push) begin
            desc_mem[desc_wr_ptr_reg] <= {cpu_wbs_adr_i[20], cpu_ch,
                                          cpu_wbs_dat_i[8 +: ADDR_WIDTH],
                                          cpu_wbs_dat_i[0 +: ADDR_WIDTH]};
        end
    end

    // ---------------- FSM state ----------------
    logic [2:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cur_reg, cur_next;
    logic [ADDR_WIDTH-1:0] last_reg, last_next;
    logic [CH_W-1:0]       ch_reg, ch_next;
    logic                  fs_reg, fs_next;
    logic [BC_W-1:0]       beat_reg, beat_next;
    logic                  cyc_reg, cyc_next;
    logic [7:0]            done_cnt_reg, done_cnt_next;
    logic                  err_reg, err_next;
    logic [ADDR_WIDTH-1:0] span;
    logic                  misaligned;

    // Modular distance so that a wrapped descriptor (last < start) is legal.
    assign span       = last_reg - cur_reg;
    assign misaligned = |(span & ADDR_WIDTH'(BURST_LEN - 1));
    assign desc_pop   = (state_reg == S_IDLE) & (desc_cnt_reg != '0);

    // ---------------- output buffer ----------------
    logic [OBUF_W-1:0] obuf_mem [OBUF_DEPTH];
    logic [OP_W-1:0]   obuf_wr_ptr_reg, obuf_rd_ptr_reg;
    logic [OC_W-1:0]   obuf_cnt_reg;
    logic [OC_W-1:0]   obuf_free;
    logic [OBUF_W-1:0] obuf_head;
    logic [CH_W-1:0]   head_ch;
    logic              obuf_empty;
    logic              obuf_push;
    logic              obuf_pop;

    assign obuf_free  = OC_W'(OBUF_DEPTH) - obuf_cnt_reg;
    assign obuf_head  = obuf_mem[obuf_rd_ptr_reg];
    assign head_ch    = obuf_head[DATA_WIDTH +: CH_W];
    assign obuf_empty = (obuf_cnt_reg == '0);
    // Beats are only accepted in WAIT; the FSM leaves WAIT on the last beat,
    // so surplus beats and beats after a reset are dropped here.
    assign obuf_push  = (state_reg == S_WAIT) & dram_burst_en_o;
    assign obuf_pop   = ~obuf_empty & acc_data_ready_o[head_ch];

    always_ff @(posedge wb_clk_i) begin
        if (obuf_push) begin
            obuf_mem[obuf_wr_ptr_reg] <= {ch_reg, dram_wbs_dat_o};
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        last_next     = last_reg;
        ch_next       = ch_reg;
        fs_next       = fs_reg;
        beat_next     = beat_reg;
        cyc_next      = cyc_reg;
        done_cnt_next = done_cnt_reg;
        err_next      = err_reg | (cpu_hit & cpu_wbs_we_i & ch_bad);
        case (state_reg)
            S_IDLE: begin
                if (desc_pop) begin
                    {fs_next, ch_next, cur_next, last_next} = desc_head;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (misaligned) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                // Issue only when a whole burst is guaranteed to fit.
                if (obuf_free >= OC_W'(BURST_LEN)) begin
                    cyc_next   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dram_wbs_ack_o | dram_burst_en_o) begin
                    cyc_next = 1'b0;
                end
                if (dram_burst_en_o) begin
                    if (beat_reg == BC_W'(BURST_LEN - 1)) begin
                        beat_next = '0;
                        if (cur_reg == last_reg) begin
                            state_next = S_DONE;
                        end else begin
                            cur_next   = cur_reg + ADDR_WIDTH'(BURST_LEN);
                            state_next = S_REQ;
                        end
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_cnt_next = done_cnt_reg + 8'd1;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- status word ----------------
    logic [3:0] desc_cnt4;
    logic       busy;

    assign desc_cnt4    = 4'(desc_cnt_reg);
    assign busy         = (state_reg != S_IDLE);
    assign cpu_dat_next = (cpu_hit & ~cpu_wbs_we_i) ?
                          {16'd0, done_cnt_reg, 2'd0, err_reg, busy, desc_cnt4} : 32'd0;

    // ---------------- registers ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cpu_ack_reg     <= 1'b0;
            cpu_dat_reg     <= '0;
            desc_wr_ptr_reg <= '0;
            desc_rd_ptr_reg <= '0;
            desc_cnt_reg    <= '0;
            obuf_wr_ptr_reg <= '0;
            obuf_rd_ptr_reg <= '0;
            obuf_cnt_reg    <= '0;
            state_reg       <= S_IDLE;
            cur_reg         <= '0;
            last_reg        <= '0;
            ch_reg          <= '0;
            fs_reg          <= 1'b0;
            beat_reg        <= '0;
            cyc_reg         <= 1'b0;
            done_cnt_reg    <= '0;
            err_reg         <= 1'b0;
        end else begin
            cpu_ack_reg  <= cpu_ack_next;
            cpu_dat_reg  <= cpu_dat_next;
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            last_reg     <= last_next;
            ch_reg       <= ch_next;
            fs_reg       <= fs_next;
            beat_reg     <= beat_next;
            cyc_reg      <= cyc_next;
            done_cnt_reg <= done_cnt_next;
            err_reg      <= err_next;

            if (desc_push) desc_wr_ptr_reg <= desc_wr_ptr_reg + 1'b1;
            if (desc_pop)  desc_rd_ptr_reg <= desc_rd_ptr_reg + 1'b1;
            case ({desc_push, desc_pop})
                2'b10:   desc_cnt_reg <= desc_cnt_reg + 1'b1;
                2'b01:   desc_cnt_reg <= desc_cnt_reg - 1'b1;
                default: desc_cnt_reg <= desc_cnt_reg;
            endcase

            if (obuf_push) obuf_wr_ptr_reg <= obuf_wr_ptr_reg + 1'b1;
            if (obuf_pop)  obuf_rd_ptr_reg <= obuf_rd_ptr_reg + 1'b1;
            case ({obuf_push, obuf_pop})
                2'b10:   obuf_cnt_reg <= obuf_cnt_reg + 1'b1;
                2'b01:   obuf_cnt_reg <= obuf_cnt_reg - 1'b1;
                default: obuf_cnt_reg <= obuf_cnt_reg;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign cpu_wbs_ack_o  = cpu_ack_reg;
    assign cpu_wbs_dat_o  = cpu_dat_reg;
    assign dram_wbs_cyc_i = cyc_reg;
    assign dram_wbs_stb_i = cyc_reg;
    assign dram_wbs_we_i  = 1'b0;
    assign dram_fun_sel   = fs_reg;
    assign dram_wbs_adr_i = ((state_reg == S_REQ) || (state_reg == S_WAIT)) ?
                            (DRAM_BASE | {{(30 - ADDR_WIDTH){1'b0}}, cur_reg, 2'b00}) : 32'd0;
    assign acc_data_i     = obuf_empty ? '0 : obuf_head[DATA_WIDTH-1:0];
    assign dma_done_o     = (state_reg == S_DONE);
    assign dma_err_o      = err_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_valid
            assign acc_data_valid_i[gi] = ~obuf_empty & (head_ch == CH_W'(gi));
        end
    endgenerate

    // Byte selects and the undecoded address/data bits have no function.
    logic unused_bits;
    assign unused_bits = ^{cpu_wbs_sel_i, cpu_wbs_adr_i, cpu_wbs_dat_i};

endmodule
